output_terminal_p: RTL



---
 rtl/output_terminal_pkg.sv | 23 ++
 rtl/ot_lane_shifter.sv | 31 +++
 rtl/output_terminal_p.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/output_terminal_pkg.sv
// Shared definitions for the output terminal.
// Holds the frame FSM state type, the beats-per-frame calculation and the
// offset-binary bias constant. Imported by output_terminal_p and its sub-module.
package output_terminal_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      CALC
   } state_t;

   // Number of load beats needed to assemble one data_w word lane_w bits at a time.
   function automatic int calc_nbeat(input int data_w, input int lane_w);
      return data_w / lane_w;
   endfunction

   // Offset-binary bias: only the MSB of a data_w word set.
   // The same value is also the most negative two's-complement word.
   function automatic logic [63:0] bias_const(input int data_w);
      return 64'd1 << (data_w - 1);
   endfunction

endpackage

// File: rtl/ot_lane_shifter.sv
// One channel's LSB-first assembly register.
// Each enabled cycle the word shifts right by LANE_W and the new lane
// enters at the MSB end, so the first beat loaded ends up as the LSBs.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset, clears the word
//   en   - shift enable (one beat)
//   lane - LANE_W input bits for this beat
//   word - assembled DATA_W word
module ot_lane_shifter #(
   parameter int DATA_W = 12,
   parameter int LANE_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [LANE_W-1:0] lane,
   output logic [DATA_W-1:0] word
);

   // Shift register: new lane bits always enter at the top so that after
   // DATA_W/LANE_W beats the earliest beat has walked down to bit 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
      end else if (en) begin
         word <= {lane, word[DATA_W-1:LANE_W]};
      end
   end

endmodule

// File: rtl/output_terminal_p.sv
// Parametrised output terminal.
// After a start pulse, collects NCH channel words LANE_W bits per cycle
// (LSB-first), optionally negates them, adds an offset-binary bias and
// registers the results. dout shows the result of channel sel_ch.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   sel_ch   - channel routed to dout (values >= NCH read as zero)
//   sel_sign - 1: add 2^(DATA_W-1) (offset binary), 0: two's complement
//   din      - load lanes, channel c at bits [c*LANE_W +: LANE_W]
//   start    - single-cycle frame request
//   is_in    - negate the frame's words (latched on the last load beat)
//   dout     - processed word of channel sel_ch
//   vld      - one-cycle strobe when new results are registered
//   busy     - frame in progress, through the vld cycle
//   ovr      - sticky: start arrived while a frame was in progress
//   sat      - sticky: most-negative word was saturated on negation
//              (only present with OUTPUT_TERMINAL_SAT_NEG_EN defined)
// Build option: define OUTPUT_TERMINAL_SAT_NEG_EN to saturate neg() of the
// most negative word instead of letting it wrap onto itself.
// NCH must be at least 2 so that sel_ch has a non-zero width.
module output_terminal_p #(
   parameter int DATA_W = 12,
   parameter int LANE_W = 2,
   parameter int NCH    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [$clog2(NCH)-1:0]  sel_ch,
   input  logic                    sel_sign,
   input  logic [NCH*LANE_W-1:0]   din,
   input  logic                    start,
   input  logic                    is_in,
   output logic [DATA_W-1:0]       dout,
   output logic                    vld,
   output logic                    busy,
   output logic                    ovr
`ifdef OUTPUT_TERMINAL_SAT_NEG_EN
   ,
   output logic                    sat
`endif
);

   import output_terminal_pkg::*;

   localparam int                NBEAT = calc_nbeat(DATA_W, LANE_W);
   localparam int                CNT_W = $clog2(NBEAT + 1);
   localparam logic [DATA_W-1:0] BIAS  = DATA_W'(bias_const(DATA_W));

   state_t             state;
   state_t             state_nxt;
   logic               load_en;
   logic               calc_en;
   logic               last_beat;
   logic               start_ok;
   logic               overrun;
   logic [CNT_W-1:0]   beat_cnt;
   logic               neg_q;
   logic [DATA_W-1:0]  words     [NCH];
   logic [DATA_W-1:0]  signed_w  [NCH];
   logic [DATA_W-1:0]  res_nxt   [NCH];
   logic [DATA_W-1:0]  results   [NCH];
`ifdef OUTPUT_TERMINAL_SAT_NEG_EN
   logic [NCH-1:0]     sat_hit;
`endif

   // One shift register per channel, all stepping together during LOAD.
   for (genvar c = 0; c < NCH; c++) begin : g_lane
      ot_lane_shifter #(
         .DATA_W (DATA_W),
         .LANE_W (LANE_W)
      ) u_shift (
         .clk  (clk),
         .rst  (rst),
         .en   (load_en),
         .lane (din[c*LANE_W +: LANE_W]),
         .word (words[c])
      );
   end

   assign last_beat = (beat_cnt == CNT_W'(NBEAT - 1));
   assign start_ok  = start && (state == IDLE);
   // A start seen in LOAD or CALC is dropped but remembered as an overrun.
   assign overrun   = start && (state != IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic: IDLE waits for start, LOAD runs NBEAT beats,
   // CALC is a single cycle that registers the results.
   always_comb begin
      state_nxt = state;
      load_en   = 1'b0;
      calc_en   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = LOAD;
         end
         LOAD: begin
            load_en = 1'b1;
            if (last_beat) state_nxt = CALC;
         end
         CALC: begin
            calc_en   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Per-channel arithmetic: optional negation, then the bias, all modulo
   // 2^DATA_W. The bias uses sel_sign as it is at the CALC edge.
   always_comb begin
`ifdef OUTPUT_TERMINAL_SAT_NEG_EN
      sat_hit = '0;
`endif
      for (int c = 0; c < NCH; c++) begin
         signed_w[c] = neg_q ? (~words[c] + DATA_W'(1)) : words[c];
`ifdef OUTPUT_TERMINAL_SAT_NEG_EN
         // The most negative word has no positive twin; clamp to the
         // largest positive value instead of wrapping back onto itself.
         if (neg_q && (words[c] == BIAS)) begin
            signed_w[c] = BIAS - DATA_W'(1);
            sat_hit[c]  = 1'b1;
         end
`else
         // Negating the most negative word wraps back onto itself.
`endif
         res_nxt[c] = signed_w[c] + (sel_sign ? BIAS : '0);
      end
   end

   // Frame bookkeeping and result registers. The beat counter restarts on an
   // accepted start, is_in is captured on the final load beat, and results
   // plus the vld strobe are written at the CALC edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt <= '0;
         neg_q    <= 1'b0;
         vld      <= 1'b0;
         ovr      <= 1'b0;
`ifdef OUTPUT_TERMINAL_SAT_NEG_EN
         sat      <= 1'b0;
`endif
         for (int c = 0; c < NCH; c++) results[c] <= '0;
      end else begin
         vld <= calc_en;
         if (overrun) ovr <= 1'b1;
         if (start_ok) begin
            beat_cnt <= '0;
         end else if (load_en) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
         end
         if (load_en && last_beat) neg_q <= is_in;
         if (calc_en) begin
            for (int c = 0; c < NCH; c++) results[c] <= res_nxt[c];
`ifdef OUTPUT_TERMINAL_SAT_NEG_EN
            if (|sat_hit) sat <= 1'b1;
`endif
         end
      end
   end

   // busy covers the whole frame including the cycle where vld is high.
   assign busy = (state != IDLE) || vld;

   // Output mux; out-of-range channel selects read as zero.
   always_comb begin
      dout = '0;
      if (int'(sel_ch) < NCH) dout = results[sel_ch];
   end

endmodule
